// File: rtl/threshold_compare_scheduler.sv
// threshold_compare_scheduler
//
// Shares a single unsigned threshold comparator among NUM_CH sample
// requesters. A round-robin arbiter picks one valid requester per cycle
// when the one-entry result slot can take a new result. The chosen sample
// is compared against that channel's programmable threshold. The result
// (channel, sample, above flag) is registered one cycle after the handshake.
// Each channel has a saturating counter of above-threshold events.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   req_valid    in   [NUM_CH]         per-channel sample valid
//   req_data     in   [NUM_CH*DATA_W]  packed samples, ch i at [i*DATA_W +: DATA_W]
//   req_ready    out  [NUM_CH]         one-hot grant (combinational)
//   cfg_we       in   threshold write strobe
//   cfg_ch       in   [CH_W]           threshold write channel
//   cfg_thresh   in   [DATA_W]         threshold write value
//   res_ready    in   downstream accepts result
//   res_valid    out  result slot full
//   res_ch       out  [CH_W]           channel of the result
//   res_above    out  sample >= threshold of that channel
//   res_value    out  [DATA_W]         compared sample
//   cnt_rd_ch    in   [CH_W]           counter read select
//   cnt_rd_data  out  [CNT_W]          selected counter (combinational)
//   cnt_clr      in   clear all counters
module threshold_compare_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = 8,
  parameter int CNT_W          = 8,
  parameter int DEFAULT_THRESH = 8,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [DATA_W-1:0]        cfg_thresh,
  input  logic                     res_ready,
  output logic                     res_valid,
  output logic [CH_W-1:0]          res_ch,
  output logic                     res_above,
  output logic [DATA_W-1:0]        res_value,
  input  logic [CH_W-1:0]          cnt_rd_ch,
  output logic [CNT_W-1:0]         cnt_rd_data,
  input  logic                     cnt_clr
);

  localparam logic [DATA_W-1:0] DEF_THRESH = DATA_W'(DEFAULT_THRESH);

  // Unsigned full-width compare; equality counts as above.
  function automatic logic is_above(input logic [DATA_W-1:0] sample,
                                    input logic [DATA_W-1:0] thresh);
    return sample >= thresh;
  endfunction

  // Saturating increment: holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) return c;
    return c + 1'b1;
  endfunction

  logic [CH_W-1:0]   ptr_q;
  logic [DATA_W-1:0] thresh_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic              res_valid_q;
  logic [CH_W-1:0]   res_ch_q;
  logic              res_above_q;
  logic [DATA_W-1:0] res_value_q;

  logic              slot_free;
  logic              found;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   idx;
  logic              xfer;
  logic [DATA_W-1:0] sel_data;
  logic              sel_above;

  assign slot_free = !res_valid_q || res_ready;

  // Round-robin search starting at the pointer. NUM_CH is a power of two,
  // so the CH_W-bit add wraps modulo NUM_CH on its own.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr_q + CH_W'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // Grant is held off during reset so no request can be consumed then.
  assign xfer = found && slot_free && !rst;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant] = 1'b1;
  end

  // Compare uses the registered threshold, so a same-cycle cfg write to the
  // granted channel only affects later compares.
  assign sel_data  = req_data[grant*DATA_W +: DATA_W];
  assign sel_above = is_above(sel_data, thresh_q[grant]);

  // ---- result / config / counter register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_above_q <= 1'b0;
      res_value_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        thresh_q[i] <= DEF_THRESH;
        cnt_q[i]    <= '0;
      end
    end else begin
      if (cfg_we) thresh_q[cfg_ch] <= cfg_thresh;

      if (xfer) begin
        res_valid_q <= 1'b1;
        res_ch_q    <= grant;
        res_value_q <= sel_data;
        res_above_q <= sel_above;
        ptr_q       <= grant + 1'b1;
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
      end

      // Clear wins over a simultaneous increment.
      if (cnt_clr) begin
        for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      end else if (xfer && sel_above) begin
        cnt_q[grant] <= sat_inc(cnt_q[grant]);
      end
    end
  end

  assign res_valid   = res_valid_q;
  assign res_ch      = res_ch_q;
  assign res_above   = res_above_q;
  assign res_value   = res_value_q;
  assign cnt_rd_data = cnt_q[cnt_rd_ch];

endmodule

// File: tb/tb_threshold_compare_scheduler.sv
module tb_threshold_compare_scheduler;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;
  localparam int CH_W   = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH*DATA_W-1:0] req_data;
  logic [NUM_CH-1:0]        req_ready;
  logic                     cfg_we;
  logic [CH_W-1:0]          cfg_ch;
  logic [DATA_W-1:0]        cfg_thresh;
  logic                     res_ready;
  logic                     res_valid;
  logic [CH_W-1:0]          res_ch;
  logic                     res_above;
  logic [DATA_W-1:0]        res_value;
  logic [CH_W-1:0]          cnt_rd_ch;
  logic [CNT_W-1:0]         cnt_rd_data;
  logic                     cnt_clr;

  int n_cmp = 0;
  int n_err = 0;

  threshold_compare_scheduler #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .DEFAULT_THRESH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_thresh(cfg_thresh),
    .res_ready(res_ready), .res_valid(res_valid), .res_ch(res_ch),
    .res_above(res_above), .res_value(res_value),
    .cnt_rd_ch(cnt_rd_ch), .cnt_rd_data(cnt_rd_data), .cnt_clr(cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [DATA_W-1:0] v);
    req_data[ch*DATA_W +: DATA_W] = v;
  endtask

  task automatic check_cnt(input string tag, input int ch, input int exp);
    cnt_rd_ch = CH_W'(ch);
    #1;
    check(tag, 32'(cnt_rd_data), 32'(exp));
  endtask

  task automatic check_res(input string tag, input int ch, input int val, input int above);
    check({tag, "_vld"}, 32'(res_valid), 32'd1);
    check({tag, "_ch"},  32'(res_ch),    32'(ch));
    check({tag, "_val"}, 32'(res_value), 32'(val));
    check({tag, "_abv"}, 32'(res_above), 32'(above));
  endtask

  int rr_a[8] = '{2, 3, 0, 1, 2, 3, 0, 1};
  int rr_b[4] = '{2, 3, 2, 3};

  initial begin
    rst = 1'b1; req_valid = '1; req_data = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_thresh = '0; res_ready = 1'b1; cnt_rd_ch = '0; cnt_clr = 1'b0;

    // Reset: no grants while rst is high.
    step();
    check("rst_rdy0", 32'(req_ready), 32'd0);
    step();
    check("rst_rdy1", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_vld",   32'(res_valid), 32'd0);
    check("rst_ch",    32'(res_ch),    32'd0);
    check("rst_abv",   32'(res_above), 32'd0);
    check("rst_val",   32'(res_value), 32'd0);
    check("rst_grant", 32'(req_ready), 32'b0001);
    for (int i = 0; i < NUM_CH; i++) check_cnt("rst_cnt", i, 0);
    req_valid = '0;
    #1;

    // Threshold boundary on ch1 with default threshold 8.
    req_valid = 4'b0010;
    set_data(1, 8'd7);
    #1;
    check("thr_rdy7", 32'(req_ready), 32'b0010);
    step();
    check_res("thr7", 1, 7, 0);
    set_data(1, 8'd8);
    #1;
    check("thr_rdy8", 32'(req_ready), 32'b0010);
    step();
    check_res("thr8", 1, 8, 1);
    set_data(1, 8'd9);
    step();
    check_res("thr9", 1, 9, 1);
    req_valid = '0;
    step();
    check("thr_drain", 32'(res_valid), 32'd0);
    check_cnt("thr_cnt1", 1, 2);

    // Round-robin with all channels valid; pointer sits at 2 after ch1.
    for (int i = 0; i < NUM_CH; i++) set_data(i, DATA_W'(i + 1));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr4_grant", 32'(req_ready), 32'(1 << rr_a[k]));
      step();
      check_res("rr4", rr_a[k], rr_a[k] + 1, 0);
    end
    req_valid = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr2_grant", 32'(req_ready), 32'(1 << rr_b[k]));
      step();
      check_res("rr2", rr_b[k], rr_b[k] + 1, 0);
    end
    req_valid = '0;
    step();
    check("rr_drain", 32'(res_valid), 32'd0);

    // Backpressure: pointer is 0 now.
    res_ready = 1'b0;
    req_valid = 4'b0001;
    set_data(0, 8'd50);
    #1;
    check("bp_rdy0", 32'(req_ready), 32'b0001);
    step();
    check_res("bp_first", 0, 50, 1);
    req_valid = 4'b0010;
    set_data(1, 8'd60);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_stall_rdy", 32'(req_ready), 32'd0);
      step();
      check_res("bp_hold", 0, 50, 1);
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(req_ready), 32'b0010);
    step();
    check_res("bp_next", 1, 60, 1);
    req_valid = '0;
    step();
    check_cnt("bp_cnt0", 0, 1);
    check_cnt("bp_cnt1", 1, 3);

    // Config race: pointer is 2, ch0 is the only requester.
    req_valid = 4'b0001;
    set_data(0, 8'd100);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_thresh = 8'd200;
    #1;
    check("cfg_rdy", 32'(req_ready), 32'b0001);
    step();
    cfg_we = 1'b0;
    check_res("cfg_old", 0, 100, 1);
    step();
    check_res("cfg_new", 0, 100, 0);
    req_valid = '0;
    step();
    check_cnt("cfg_cnt0", 0, 2);

    // Counter saturation on ch3 (CNT_W = 2).
    req_valid = 4'b1000;
    set_data(3, 8'd200);
    for (int k = 0; k < 3; k++) step();
    check_cnt("sat_cnt3_3", 3, 3);
    step();
    step();
    check_cnt("sat_cnt3_5", 3, 3);
    check_res("sat_res", 3, 200, 1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check_cnt("clr_cnt3", 3, 0);
    check_cnt("clr_cnt0", 0, 0);
    check_cnt("clr_cnt1", 1, 0);
    step();
    check_cnt("post_clr_cnt3", 3, 1);
    req_valid = '0;
    step();

    // Mid-run reset restores the default threshold on ch0 and drops the slot.
    res_ready = 1'b0;
    req_valid = 4'b0001;
    set_data(0, 8'd8);
    step();
    check("mid_vld", 32'(res_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_rdy", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    res_ready = 1'b1;
    #1;
    check("mid_rst_vld", 32'(res_valid), 32'd0);
    check("mid_rst_grant", 32'(req_ready), 32'b0001);
    step();
    check_res("mid_def_thr", 0, 8, 1);
    req_valid = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/threshold_compare_scheduler.md
Name: threshold_compare_scheduler

Overview:
- Shares one threshold comparator between NUM_CH sample requesters using round-robin arbitration.
- Holds a programmable 8-bit threshold per channel and returns a registered above/below result tagged with the channel ID.
- Keeps a saturating per-channel count of above-threshold events.
- Sits between the sensor sample sources and downstream event logic; it is the sequencing front end for the threshold-compare datapath.

Parameters:
- NUM_CH, 4, number of requesting channels (power of 2, 2..8)
- DATA_W, 8, sample and threshold width
- CNT_W, 8, event counter width
- DEFAULT_THRESH, 8, threshold loaded into every channel at reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_CH  per-channel sample valid
- req_data  in  NUM_CH*DATA_W  packed samples; channel i is at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_CH  one-hot grant/accept; combinational
- cfg_we  in  1  threshold write strobe
- cfg_ch  in  log2(NUM_CH)  threshold write channel
- cfg_thresh  in  DATA_W  threshold write value
- res_ready  in  1  downstream accepts result
- res_valid  out  1  result slot full
- res_ch  out  log2(NUM_CH)  channel of the result
- res_above  out  1  1 when sample >= that channel's threshold
- res_value  out  DATA_W  sample that was compared
- cnt_rd_ch  in  log2(NUM_CH)  counter read select
- cnt_rd_data  out  CNT_W  selected counter; combinational read
- cnt_clr  in  1  clears all counters

Behaviour:
- Reset (rst=1 at a clk edge) produces:
  - res_valid=0, res_ch=0, res_above=0, res_value=0.
  - Every threshold = DEFAULT_THRESH, every counter = 0.
  - Round-robin pointer = 0, so channel 0 has highest priority.
  - Any pending result is dropped.
  - req_ready = 0 while rst is high.
- Output slot has two states:
  - EMPTY (res_valid=0) and FULL (res_valid=1).
  - slot_free = !res_valid || res_ready.
- Arbitration, evaluated every cycle:
  - If slot_free, grant g = the first channel with req_valid set, searching pointer, pointer+1, … modulo NUM_CH.
  - req_ready[g]=1; all other bits are 0.
  - If !slot_free or no channel is valid, req_ready=0.
- Transfer occurs when req_valid[g] && req_ready[g]. At the next edge:
  - res_valid=1, res_ch=g, res_value=sample, res_above=(sample >= thresh[g]).
  - Pointer moves to (g+1) mod NUM_CH.
- With no transfer, the pointer holds.
- If res_ready=1 and there is no new transfer, res_valid goes 0 next edge.
- Back-to-back: a full slot with res_ready=1 accepts a new transfer in the same cycle. Throughput is 1 compare/cycle; latency is 1 cycle from handshake to res_valid.
- Result fields are stable while res_valid=1 && res_ready=0.
- Compare is unsigned, full DATA_W, with no rounding. Equality counts as above.
- Requester rules:
  - A requester holds req_valid and req_data stable until accepted.
  - The block never drops an asserted request.
  - Starvation bound: at most NUM_CH-1 other grants between two grants to the same continuously-valid channel.
- Threshold write: on cfg_we, thresh[cfg_ch] <= cfg_thresh at the edge. A compare in the same cycle on the same channel uses the old threshold.
- Counters:
  - cnt[g] increments when a transfer produces res_above=1. The increment is applied at the same edge as the result register load.
  - Counters saturate at 2^CNT_W-1.
  - cnt_clr clears all counters and wins over a simultaneous increment.
  - rst wins over everything.

Test Plan:
- Reset: hold rst 2 cycles with all req_valid=1 -> req_ready=0 throughout. After release, all outputs are 0, cnt_rd_data=0 for every channel, and ch0 is granted first.
- Threshold boundary: ch1 sends 7, 8, 9 with default threshold 8, res_ready=1 -> res_above = 0, 1, 1 and res_ch=1 for each. cnt[1]=2. Each result appears exactly 1 cycle after its handshake.
- Round-robin fairness: all 4 channels continuously valid, res_ready=1 -> grant order 0,1,2,3,0,1,… and one result every cycle. Repeat with only ch2 and ch3 valid -> grants alternate 2,3.
- Backpressure: slot full, res_ready=0 for 3 cycles -> req_ready=0, and res_* hold value/ch stable. On res_ready=1, the next grant occurs in that same cycle.
- Config race: cfg_we writes ch0 threshold=200 in the same cycle ch0 sample 100 is accepted -> res_above=1 (old threshold 8). Next ch0 sample 100 -> res_above=0.
- Counter saturation and clear: with CNT_W=2, 5 above events on ch3 -> cnt=3. cnt_clr asserted together with an above event -> cnt=0.
